tournament_predictor: RTL and testbench

- Parametrised next-generation hybrid (tournament) branch predictor for the 5-stage core; sits beside IF, queried every fetch, trained from MEM.
- Combines a gshare global predictor, a two-level local predictor and a per-PC meta chooser with a tagged direct-mapped BTB.
- Adds over the previous hybrid: configurable table sizes and counter width, a speculative global-history register (GHR) with mispredict recovery, and tagged BTB entries with an unconditional-jump flag.

---
 rtl/bp_pkg.sv | 48 ++++
 rtl/sat_counter_table.sv | 33 +++
 rtl/tournament_predictor.sv | 167 ++++++++++++++++
 tb/tb_tournament_predictor.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the tournament branch predictor: counter
// stepping/reset value, BTB entry layout and PC field extraction.
package bp_pkg;

  localparam int unsigned CTR_MAX_W = 8;
  localparam int unsigned ADDR_W    = 32;

  typedef struct packed {
    logic              valid;
    logic              uncond;
    logic [ADDR_W-1:0] tag;
    logic [ADDR_W-1:0] target;
  } btb_entry_t;

  // Weakly not-taken value for a w-bit counter.
  function automatic logic [CTR_MAX_W-1:0] ctr_reset_val(input int unsigned w);
    return CTR_MAX_W'((64'd1 << (w - 1)) - 64'd1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_step(input logic [CTR_MAX_W-1:0] c,
                                                    input logic                 up,
                                                    input int unsigned          w);
    logic [CTR_MAX_W-1:0] cmax;
    cmax = CTR_MAX_W'((64'd1 << w) - 64'd1);
    if (up) return (c == cmax) ? c : c + CTR_MAX_W'(1);
    return (c == '0) ? c : c - CTR_MAX_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] bit_field(input logic [ADDR_W-1:0] pc,
                                                  input int unsigned       lsb,
                                                  input int unsigned       w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return ADDR_W'((64'(pc) >> lsb) & mask);
  endfunction

  function automatic logic [ADDR_W-1:0] pc_index(input logic [ADDR_W-1:0] pc,
                                                 input int unsigned       w);
    return bit_field(pc, 2, w);
  endfunction

  function automatic logic [ADDR_W-1:0] btb_tag(input logic [ADDR_W-1:0] pc,
                                                input int unsigned       idx_w,
                                                input int unsigned       tag_w);
    return bit_field(pc, idx_w + 2, tag_w);
  endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Table of saturating counters: one combinational read port and one
// read-before-write update port that steps a counter toward upd_up.
module sat_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 10,
  parameter int unsigned CTR_W = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr_c,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_up
);

  localparam int unsigned      DEPTH   = 32'd1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_reset_val(CTR_W));

  logic [CTR_W-1:0] mem_q [DEPTH];

  assign rd_ctr_c = mem_q[rd_idx];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[IDX_W'(i)] <= CTR_RST;
    end else if (upd_en) begin
      mem_q[upd_idx] <= CTR_W'(ctr_step(CTR_MAX_W'(mem_q[upd_idx]), upd_up, CTR_W));
    end
  end

endmodule

// File: rtl/tournament_predictor.sv
// Tournament branch predictor (gshare + two-level local + meta chooser, tagged BTB).
// Define TOURNAMENT_STATS_EN to add lookup/mispredict statistics counters.
module tournament_predictor
  import bp_pkg::*;
#(
  parameter int unsigned PHT_IDX_W = 10,
  parameter int unsigned GHR_W     = 8,
  parameter int unsigned LHT_IDX_W = 8,
  parameter int unsigned LH_W      = 8,
  parameter int unsigned CTR_W     = 2,
  parameter int unsigned BTB_IDX_W = 6,
  parameter int unsigned TAG_W     = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             lookup_valid,
  input  logic [31:0]      lookup_pc,
  input  logic             lookup_is_cond,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  output logic [GHR_W-1:0] pred_ghr,
  output logic             pred_global,
  output logic             pred_local,
  input  logic             update_valid,
  input  logic [31:0]      update_pc,
  input  logic             update_is_cond,
  input  logic             update_taken,
  input  logic [31:0]      update_target,
  input  logic             update_pred_taken,
  input  logic             update_global,
  input  logic             update_local,
  input  logic [GHR_W-1:0] update_ghr
`ifdef TOURNAMENT_STATS_EN
  ,
  output logic [31:0]      stat_lookups,
  output logic [31:0]      stat_mispredicts
`endif
);

  localparam int unsigned LHT_DEPTH = 32'd1 << LHT_IDX_W;
  localparam int unsigned BTB_DEPTH = 32'd1 << BTB_IDX_W;

  logic [GHR_W-1:0] ghr_q;
  logic [LH_W-1:0]  lht_q [LHT_DEPTH];
  btb_entry_t       btb_q [BTB_DEPTH];

  logic [PHT_IDX_W-1:0] lk_meta_idx, lk_gsh_idx, up_meta_idx, up_gsh_idx;
  logic [LHT_IDX_W-1:0] lk_lht_idx, up_lht_idx;
  logic [BTB_IDX_W-1:0] lk_btb_idx, up_btb_idx;
  logic [LH_W-1:0]      lk_lhist, up_lhist;
  logic [CTR_W-1:0]     gsh_ctr, loc_ctr, meta_ctr;
  btb_entry_t           lk_entry;
  logic                 lk_hit, lk_global, lk_local, lk_taken, lk_accept;
  logic                 up_cond, up_meta_en, recover;

  // Lookup side: all tables read combinationally from the fetch PC.
  assign lk_meta_idx = PHT_IDX_W'(pc_index(lookup_pc, PHT_IDX_W));
  assign lk_gsh_idx  = lk_meta_idx ^ PHT_IDX_W'(ghr_q);
  assign lk_lht_idx  = LHT_IDX_W'(pc_index(lookup_pc, LHT_IDX_W));
  assign lk_lhist    = lht_q[lk_lht_idx];
  assign lk_btb_idx  = BTB_IDX_W'(pc_index(lookup_pc, BTB_IDX_W));
  assign lk_entry    = btb_q[lk_btb_idx];
  assign lk_hit      = lk_entry.valid & (lk_entry.tag == btb_tag(lookup_pc, BTB_IDX_W, TAG_W));
  assign lk_global   = gsh_ctr[CTR_W-1];
  assign lk_local    = loc_ctr[CTR_W-1];
  assign lk_taken    = lk_hit & (lk_entry.uncond | (meta_ctr[CTR_W-1] ? lk_global : lk_local));
  assign lk_accept   = lookup_valid & ~FLUSH;

  // Update side: gshare trains with the history the branch was predicted under.
  assign up_meta_idx = PHT_IDX_W'(pc_index(update_pc, PHT_IDX_W));
  assign up_gsh_idx  = up_meta_idx ^ PHT_IDX_W'(update_ghr);
  assign up_lht_idx  = LHT_IDX_W'(pc_index(update_pc, LHT_IDX_W));
  assign up_lhist    = lht_q[up_lht_idx];
  assign up_btb_idx  = BTB_IDX_W'(pc_index(update_pc, BTB_IDX_W));
  assign up_cond     = update_valid & update_is_cond;
  assign up_meta_en  = up_cond & (update_global != update_local);
  assign recover     = up_cond & (update_taken != update_pred_taken);

  sat_counter_table #(.IDX_W(PHT_IDX_W), .CTR_W(CTR_W)) u_gshare (
    .CLK(CLK), .RESET(RESET), .rd_idx(lk_gsh_idx), .rd_ctr_c(gsh_ctr),
    .upd_en(up_cond), .upd_idx(up_gsh_idx), .upd_up(update_taken)
  );

  sat_counter_table #(.IDX_W(LH_W), .CTR_W(CTR_W)) u_local (
    .CLK(CLK), .RESET(RESET), .rd_idx(lk_lhist), .rd_ctr_c(loc_ctr),
    .upd_en(up_cond), .upd_idx(up_lhist), .upd_up(update_taken)
  );

  sat_counter_table #(.IDX_W(PHT_IDX_W), .CTR_W(CTR_W)) u_meta (
    .CLK(CLK), .RESET(RESET), .rd_idx(lk_meta_idx), .rd_ctr_c(meta_ctr),
    .upd_en(up_meta_en), .upd_idx(up_meta_idx), .upd_up(update_global == update_taken)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
      pred_ghr    <= '0;
      pred_global <= 1'b0;
      pred_local  <= 1'b0;
    end else begin
      pred_valid  <= lk_accept;
      pred_taken  <= lk_taken;
      pred_target <= lk_hit ? lk_entry.target : '0;
      pred_ghr    <= ghr_q;
      pred_global <= lk_global;
      pred_local  <= lk_local;
    end
  end

  // Speculative history; a resolved mispredict rebuilds it from the returned snapshot.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ghr_q <= '0;
    end else if (recover) begin
      ghr_q <= {update_ghr[GHR_W-2:0], update_taken};
    end else if (lk_accept & lookup_is_cond) begin
      ghr_q <= {ghr_q[GHR_W-2:0], lk_taken};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < LHT_DEPTH; i++) lht_q[LHT_IDX_W'(i)] <= '0;
    end else if (up_cond) begin
      lht_q[up_lht_idx] <= {up_lhist[LH_W-2:0], update_taken};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < BTB_DEPTH; i++) btb_q[BTB_IDX_W'(i)] <= '0;
    end else if (update_valid & update_taken) begin
      btb_q[up_btb_idx] <= '{valid:  1'b1,
                             uncond: ~update_is_cond,
                             tag:    btb_tag(update_pc, BTB_IDX_W, TAG_W),
                             target: update_target};
    end
  end

`ifdef TOURNAMENT_STATS_EN
  btb_entry_t  up_entry;
  logic        up_hit, up_mispred;
  logic [31:0] up_pred_target;

  // The predicted target is what the BTB holds for the resolved PC before this update.
  assign up_entry       = btb_q[up_btb_idx];
  assign up_hit         = up_entry.valid & (up_entry.tag == btb_tag(update_pc, BTB_IDX_W, TAG_W));
  assign up_pred_target = up_hit ? up_entry.target : '0;
  assign up_mispred     = (update_taken != update_pred_taken) |
                          (update_taken & (update_target != up_pred_target));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (lk_accept) stat_lookups <= stat_lookups + 32'd1;
      if (update_valid & up_mispred) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tournament_predictor.sv
// Bench for tournament_predictor: directed steps then random traffic, all
// checked against an array-based reference model (TOURNAMENT_STATS_EN aware).
module tb_tournament_predictor;

  localparam int unsigned PHT_IDX_W = 10;
  localparam int unsigned GHR_W     = 8;
  localparam int unsigned LHT_IDX_W = 8;
  localparam int unsigned LH_W      = 8;
  localparam int unsigned CTR_W     = 2;
  localparam int unsigned BTB_IDX_W = 6;
  localparam int unsigned TAG_W     = 16;

  localparam int unsigned PHT_N  = 1 << PHT_IDX_W;
  localparam int unsigned LHT_N  = 1 << LHT_IDX_W;
  localparam int unsigned LPHT_N = 1 << LH_W;
  localparam int unsigned BTB_N  = 1 << BTB_IDX_W;
  localparam int unsigned TAG_N  = 1 << TAG_W;
  localparam int unsigned GHR_N  = 1 << GHR_W;
  localparam int unsigned CMAX   = (1 << CTR_W) - 1;
  localparam int unsigned CRST   = (1 << (CTR_W - 1)) - 1;
  localparam int unsigned CTHR   = 1 << (CTR_W - 1);

  logic             CLK = 1'b0;
  logic             RESET, FLUSH, lookup_valid, lookup_is_cond;
  logic [31:0]      lookup_pc;
  logic             pred_valid, pred_taken, pred_global, pred_local;
  logic [31:0]      pred_target;
  logic [GHR_W-1:0] pred_ghr;
  logic             update_valid, update_is_cond, update_taken;
  logic             update_pred_taken, update_global, update_local;
  logic [31:0]      update_pc, update_target;
  logic [GHR_W-1:0] update_ghr;
`ifdef TOURNAMENT_STATS_EN
  logic [31:0]      stat_lookups, stat_mispredicts;
`endif

  tournament_predictor #(
    .PHT_IDX_W(PHT_IDX_W), .GHR_W(GHR_W), .LHT_IDX_W(LHT_IDX_W), .LH_W(LH_W),
    .CTR_W(CTR_W), .BTB_IDX_W(BTB_IDX_W), .TAG_W(TAG_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_is_cond(lookup_is_cond),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_ghr(pred_ghr), .pred_global(pred_global), .pred_local(pred_local),
    .update_valid(update_valid), .update_pc(update_pc), .update_is_cond(update_is_cond),
    .update_taken(update_taken), .update_target(update_target),
    .update_pred_taken(update_pred_taken), .update_global(update_global),
    .update_local(update_local), .update_ghr(update_ghr)
`ifdef TOURNAMENT_STATS_EN
    , .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 CLK = ~CLK;

  // Reference model state
  int unsigned m_gctr [PHT_N];
  int unsigned m_meta [PHT_N];
  int unsigned m_lctr [LPHT_N];
  int unsigned m_lht  [LHT_N];
  bit          m_bval [BTB_N];
  bit          m_bunc [BTB_N];
  int unsigned m_btag [BTB_N];
  logic [31:0] m_btgt [BTB_N];
  int unsigned m_ghr;
  logic [31:0] m_lookups, m_mispred;

  logic        exp_valid, exp_taken, exp_global, exp_local;
  logic [31:0] exp_target;
  int unsigned exp_ghr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned toward(input int unsigned c, input bit up);
    if (up) return (c < CMAX) ? c + 1 : CMAX;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(PHT_N); i++) begin m_gctr[i] = CRST; m_meta[i] = CRST; end
    for (int i = 0; i < int'(LPHT_N); i++) m_lctr[i] = CRST;
    for (int i = 0; i < int'(LHT_N); i++) m_lht[i] = 0;
    for (int i = 0; i < int'(BTB_N); i++) begin m_bval[i] = 0; m_bunc[i] = 0; m_btag[i] = 0; m_btgt[i] = '0; end
    m_ghr = 0;
    m_lookups = '0;
    m_mispred = '0;
  endtask

  task automatic idle();
    RESET = 0; FLUSH = 0;
    lookup_valid = 0; lookup_pc = '0; lookup_is_cond = 0;
    update_valid = 0; update_pc = '0; update_is_cond = 0; update_taken = 0;
    update_target = '0; update_pred_taken = 0; update_global = 0; update_local = 0;
    update_ghr = '0;
  endtask

  // Advance one clock: predict from the model's current state, apply the
  // cycle's effects to the model, then compare the DUT after the edge.
  task automatic step();
    int unsigned pidx, bidx, lh, uidx, ulh, ugidx;
    bit hit, g, l, tk, uhit, mis;
    logic [31:0] upt_tgt;
    if (RESET) begin
      exp_valid = 0; exp_taken = 0; exp_target = '0; exp_ghr = 0; exp_global = 0; exp_local = 0;
      model_reset();
    end else begin
      pidx = (lookup_pc >> 2) % PHT_N;
      lh   = m_lht[(lookup_pc >> 2) % LHT_N];
      bidx = (lookup_pc >> 2) % BTB_N;
      hit  = m_bval[bidx] && (m_btag[bidx] == (lookup_pc >> (BTB_IDX_W + 2)) % TAG_N);
      g    = m_gctr[pidx ^ m_ghr] >= CTHR;
      l    = m_lctr[lh] >= CTHR;
      tk   = hit && (m_bunc[bidx] || ((m_meta[pidx] >= CTHR) ? g : l));
      exp_valid  = lookup_valid && !FLUSH;
      exp_taken  = tk;
      exp_target = hit ? m_btgt[bidx] : 32'd0;
      exp_ghr    = m_ghr;
      exp_global = g;
      exp_local  = l;
      if (update_valid) begin
        uidx    = (update_pc >> 2) % BTB_N;
        uhit    = m_bval[uidx] && (m_btag[uidx] == (update_pc >> (BTB_IDX_W + 2)) % TAG_N);
        upt_tgt = uhit ? m_btgt[uidx] : 32'd0;
        mis     = (update_taken != update_pred_taken) || (update_taken && update_target != upt_tgt);
        if (mis) m_mispred = m_mispred + 1;
        if (update_is_cond) begin
          ugidx = ((update_pc >> 2) % PHT_N) ^ update_ghr;
          m_gctr[ugidx] = toward(m_gctr[ugidx], update_taken);
          ulh = m_lht[(update_pc >> 2) % LHT_N];
          m_lctr[ulh] = toward(m_lctr[ulh], update_taken);
          m_lht[(update_pc >> 2) % LHT_N] = ((ulh << 1) | update_taken) % LPHT_N;
          if (update_global != update_local)
            m_meta[(update_pc >> 2) % PHT_N] =
              toward(m_meta[(update_pc >> 2) % PHT_N], update_global == update_taken);
        end
        if (update_taken) begin
          m_bval[uidx] = 1;
          m_bunc[uidx] = !update_is_cond;
          m_btag[uidx] = (update_pc >> (BTB_IDX_W + 2)) % TAG_N;
          m_btgt[uidx] = update_target;
        end
      end
      if (lookup_valid && !FLUSH) m_lookups = m_lookups + 1;
      if (update_valid && update_is_cond && update_taken != update_pred_taken)
        m_ghr = ((update_ghr << 1) | update_taken) % GHR_N;
      else if (lookup_valid && lookup_is_cond && !FLUSH)
        m_ghr = ((m_ghr << 1) | tk) % GHR_N;
    end
    @(posedge CLK);
    #1;
    chk("pred_valid", 32'(pred_valid), 32'(exp_valid));
    if (exp_valid || RESET) begin
      chk("pred_taken", 32'(pred_taken), 32'(exp_taken));
      chk("pred_target", pred_target, exp_target);
      chk("pred_ghr", 32'(pred_ghr), exp_ghr);
      chk("pred_global", 32'(pred_global), 32'(exp_global));
      chk("pred_local", 32'(pred_local), 32'(exp_local));
    end
`ifdef TOURNAMENT_STATS_EN
    chk("stat_lookups", stat_lookups, m_lookups);
    chk("stat_mispredicts", stat_mispredicts, m_mispred);
`endif
  endtask

  initial begin
    idle();
    model_reset();
    RESET = 1; step();
    RESET = 1; step();
    chk("reset_valid", 32'(pred_valid), 32'd0);

    // First lookup after reset: empty BTB, zero history
    idle(); lookup_valid = 1; lookup_pc = 32'h400; lookup_is_cond = 1; step();
    chk("first_valid", 32'(pred_valid), 32'd1);
    chk("first_taken", 32'(pred_taken), 32'd0);
    chk("first_target", pred_target, 32'd0);
    chk("first_ghr", 32'(pred_ghr), 32'd0);

    // Conditional taken training installs the BTB target
    idle(); update_valid = 1; update_pc = 32'h400; update_is_cond = 1; update_taken = 1;
    update_target = 32'h480; step();
    idle(); lookup_valid = 1; lookup_pc = 32'h400; lookup_is_cond = 1; step();
    chk("cond_target", pred_target, 32'h480);

    // Unconditional jump predicts taken regardless of counters
    idle(); update_valid = 1; update_pc = 32'h500; update_is_cond = 0; update_taken = 1;
    update_target = 32'h600; step();
    idle(); lookup_valid = 1; lookup_pc = 32'h500; lookup_is_cond = 0; step();
    chk("uncond_taken", 32'(pred_taken), 32'd1);
    chk("uncond_target", pred_target, 32'h600);

    // Recovery overrides the same-cycle speculative shift
    idle(); update_valid = 1; update_pc = 32'h700; update_is_cond = 1; update_taken = 1;
    update_pred_taken = 0; update_ghr = 8'h5A; update_target = 32'h780;
    lookup_valid = 1; lookup_pc = 32'h404; lookup_is_cond = 1; step();
    idle(); lookup_valid = 1; lookup_pc = 32'h404; lookup_is_cond = 1; step();
    chk("recover_ghr", 32'(pred_ghr), 32'hB5);

    // Saturation and read-before-write at a single gshare/meta index
    idle(); update_valid = 1; update_pc = 32'h900; update_is_cond = 1; update_taken = 0;
    update_pred_taken = 1; step();
    for (int i = 0; i < 5; i++) begin
      idle(); update_valid = 1; update_pc = 32'h800; update_is_cond = 1; update_taken = 1;
      update_pred_taken = 1; update_global = 1; update_local = 0; update_target = 32'h880; step();
    end
    idle(); update_valid = 1; update_pc = 32'h800; update_is_cond = 1; update_taken = 0;
    update_pred_taken = 0; update_global = 1; update_local = 0;
    lookup_valid = 1; lookup_pc = 32'h800; lookup_is_cond = 1; step();
    chk("rbw_taken", 32'(pred_taken), 32'd1);
    chk("rbw_global", 32'(pred_global), 32'd1);
    chk("rbw_target", pred_target, 32'h880);
    idle(); update_valid = 1; update_pc = 32'h900; update_is_cond = 1; update_taken = 0;
    update_pred_taken = 1; step();
    idle(); lookup_valid = 1; lookup_pc = 32'h800; lookup_is_cond = 1; step();
    chk("sat_taken", 32'(pred_taken), 32'd1);
    chk("sat_global", 32'(pred_global), 32'd1);

    // FLUSH drops the prediction and leaves the history alone
    idle(); FLUSH = 1; lookup_valid = 1; lookup_pc = 32'h800; lookup_is_cond = 1; step();
    chk("flush_valid", 32'(pred_valid), 32'd0);
    idle(); lookup_valid = 1; lookup_pc = 32'h800; lookup_is_cond = 1; step();
    chk("flush_ghr", 32'(pred_ghr), 32'h01);

`ifdef TOURNAMENT_STATS_EN
    idle(); RESET = 1; step();
    for (int i = 0; i < 3; i++) begin
      idle(); lookup_valid = 1; lookup_pc = 32'h410; lookup_is_cond = 1; step();
    end
    idle(); update_valid = 1; update_pc = 32'h410; update_is_cond = 1; update_taken = 1;
    update_pred_taken = 0; update_target = 32'h420; step();
    chk("stats_lookups_3", stat_lookups, 32'd3);
    chk("stats_mispred_1", stat_mispredicts, 32'd1);
    idle(); RESET = 1; step();
    chk("stats_lookups_rst", stat_lookups, 32'd0);
    chk("stats_mispred_rst", stat_mispredicts, 32'd0);
`endif

    // Random traffic over a small aliasing PC pool
    for (int n = 0; n < 3000; n++) begin
      idle();
      RESET             = ($urandom_range(0, 299) == 0);
      FLUSH             = ($urandom_range(0, 9) == 0);
      lookup_valid      = ($urandom_range(0, 3) != 0);
      lookup_pc         = 32'h400 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3) << 8);
      lookup_is_cond    = ($urandom_range(0, 3) != 0);
      update_valid      = ($urandom_range(0, 1) != 0);
      update_pc         = 32'h400 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3) << 8);
      update_is_cond    = ($urandom_range(0, 3) != 0);
      update_taken      = ($urandom_range(0, 1) != 0);
      update_target     = ($urandom_range(0, 1) != 0) ? 32'h1000 : 32'($urandom);
      update_pred_taken = ($urandom_range(0, 1) != 0);
      update_global     = ($urandom_range(0, 1) != 0);
      update_local      = ($urandom_range(0, 1) != 0);
      update_ghr        = GHR_W'($urandom_range(0, GHR_N - 1));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
